// File: rtl/cnn_image_dma_if.sv
// Bus master/slave signal bundle for the CNN image DMA.
// Carries the AHB-Lite-style request, address/control, response and read-data
// signals. The DMA connects through the master modport, the bus or memory
// model through the slave modport.
//   HBUSREQ  master->slave  bus request
//   HGRANT   slave->master  bus grant
//   HTRANS   master->slave  IDLE/NONSEQ/SEQ
//   HBURST   master->slave  burst type (INCR)
//   HSIZE    master->slave  transfer size (WORD)
//   HWRITE   master->slave  write enable (always read)
//   HADDR    master->slave  transfer address
//   HREADY   slave->master  transfer ready
//   HRESP    slave->master  OKAY/ERROR
//   HRDATA   slave->master  read data
interface cnn_image_dma_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              HBUSREQ;
    logic              HGRANT;
    logic [1:0]        HTRANS;
    logic [2:0]        HBURST;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic [W_ADDR-1:0] HADDR;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [W_DATA-1:0] HRDATA;

    modport master (
        output HBUSREQ, HTRANS, HBURST, HSIZE, HWRITE, HADDR,
        input  HGRANT, HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HBUSREQ, HTRANS, HBURST, HSIZE, HWRITE, HADDR,
        output HGRANT, HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/cnn_image_dma.sv
// Input-frame loader for the CNN accelerator: reads a frame of 8-bit pixels
// (4 per word) from system memory over an AHB-Lite-style bus and writes the
// words into the input buffer at word index 0..N-1.
//   HCLK, HRESETn     clock, async active-low reset
//   i_start           rising edge starts a job (ignored while busy)
//   i_clear           clears o_done/o_err
//   i_base_addr       byte base address, bits[1:0] forced to 0
//   i_frame_size      pixel count; N = ceil(size/4) words, capped at buffer depth
//   m                 bus master port (cnn_image_dma_if.master)
//   o_buf_we/addr/wdata  buffer write, one cycle per received word
//   o_busy            job in progress
//   o_done, o_err     sticky completion / bus-error flags
//
// state   | meaning
// S_IDLE  | waiting for a start edge
// S_REQ   | bus requested, waiting for grant (initial or after grant loss)
// S_XFER  | issuing address phases, one per word
// S_DRAIN | all addresses issued, waiting for the last data phase
module cnn_image_dma #(
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int W_FRAME_SIZE = 25,
    parameter int W_BUF_ADDR   = 12
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    i_start,
    input  logic                    i_clear,
    input  logic [W_ADDR-1:0]       i_base_addr,
    input  logic [W_FRAME_SIZE-1:0] i_frame_size,
    cnn_image_dma_if.master         m,
    output logic                    o_buf_we,
    output logic [W_BUF_ADDR-1:0]   o_buf_addr,
    output logic [W_DATA-1:0]       o_buf_wdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);
    localparam int W_CNT     = W_BUF_ADDR + 1;
    localparam int W_SUM     = W_FRAME_SIZE + 1;
    localparam int MAX_WORDS = 1 << W_BUF_ADDR;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN} state_t;

    state_t                state;
    logic                  start_q;
    logic                  data_pending;
    logic [W_CNT-1:0]      n_words;
    logic [W_CNT-1:0]      issued;
    logic [W_BUF_ADDR-1:0] rcv_cnt;

    logic [W_SUM-1:0]      words_raw;
    logic [W_CNT-1:0]      words_sat;
    logic                  start_edge;
    logic                  resp_err;
    logic                  addr_ok;
    logic                  last_addr;
    logic [W_ADDR-1:0]     next_addr;

    assign m.HBURST = 3'b001;
    assign m.HSIZE  = 3'b010;
    assign m.HWRITE = 1'b0;

    // Round pixel count up to whole words, then clamp to the buffer depth.
    assign words_raw  = ({1'b0, i_frame_size} + W_SUM'(3)) >> 2;
    assign words_sat  = (words_raw > W_SUM'(MAX_WORDS)) ? W_CNT'(MAX_WORDS)
                                                         : words_raw[W_CNT-1:0];
    assign start_edge = i_start & ~start_q;

    // ERROR is acted on in its first (wait) cycle, before HREADY rises.
    assign resp_err   = data_pending && (m.HRESP == RESP_ERROR);
    assign addr_ok    = (state == S_XFER) && m.HREADY;
    assign last_addr  = (issued + W_CNT'(1)) == n_words;
    // HADDR doubles as the running address pointer (base + 4*issued).
    assign next_addr  = m.HADDR + W_ADDR'(4);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            data_pending <= 1'b0;
            n_words      <= '0;
            issued       <= '0;
            rcv_cnt      <= '0;
            m.HBUSREQ    <= 1'b0;
            m.HTRANS     <= TR_IDLE;
            m.HADDR      <= '0;
            o_buf_we     <= 1'b0;
            o_buf_addr   <= '0;
            o_buf_wdata  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            start_q  <= i_start;
            o_buf_we <= 1'b0;

            if (i_clear) begin
                o_done <= 1'b0;
                o_err  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        m.HADDR <= i_base_addr & ~W_ADDR'(3);
                        n_words <= words_sat;
                        issued  <= '0;
                        rcv_cnt <= '0;
                        o_err   <= 1'b0;
                        if (words_sat == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            o_done    <= 1'b0;
                            o_busy    <= 1'b1;
                            m.HBUSREQ <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (m.HGRANT && m.HREADY) begin
                        m.HTRANS <= TR_NONSEQ;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (addr_ok) begin
                        issued  <= issued + W_CNT'(1);
                        m.HADDR <= next_addr;
                        if (last_addr) begin
                            m.HTRANS  <= TR_IDLE;
                            m.HBUSREQ <= 1'b0;
                            state     <= S_DRAIN;
                        end else if (!m.HGRANT) begin
                            m.HTRANS <= TR_IDLE;
                            state    <= S_REQ;
                        end else begin
                            // A burst may not cross a 1KB boundary: restart it there.
                            m.HTRANS <= (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!data_pending) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Data phase runs alongside the FSM and overrides it on error.
            if (resp_err) begin
                data_pending <= 1'b0;
                m.HTRANS     <= TR_IDLE;
                m.HBUSREQ    <= 1'b0;
                o_busy       <= 1'b0;
                o_done       <= 1'b1;
                o_err        <= 1'b1;
                state        <= S_IDLE;
            end else if (m.HREADY) begin
                data_pending <= addr_ok;
                if (data_pending) begin
                    o_buf_we    <= 1'b1;
                    o_buf_addr  <= rcv_cnt;
                    o_buf_wdata <= m.HRDATA;
                    rcv_cnt     <= rcv_cnt + W_BUF_ADDR'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cnn_image_dma.sv
module tb_cnn_image_dma;
    localparam int W_ADDR       = 32;
    localparam int W_DATA       = 32;
    localparam int W_FRAME_SIZE = 25;
    localparam int W_BUF_ADDR   = 12;

    logic                    HCLK = 1'b0;
    logic                    HRESETn;
    logic                    i_start;
    logic                    i_clear;
    logic [W_ADDR-1:0]       i_base_addr;
    logic [W_FRAME_SIZE-1:0] i_frame_size;
    logic                    o_buf_we;
    logic [W_BUF_ADDR-1:0]   o_buf_addr;
    logic [W_DATA-1:0]       o_buf_wdata;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_err;

    cnn_image_dma_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

    cnn_image_dma #(
        .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .W_FRAME_SIZE(W_FRAME_SIZE), .W_BUF_ADDR(W_BUF_ADDR)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .i_start(i_start), .i_clear(i_clear),
        .i_base_addr(i_base_addr), .i_frame_size(i_frame_size),
        .m(bus),
        .o_buf_we(o_buf_we), .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_we_cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // scoreboard of {buffer address, data}
    logic [43:0] sb_q[$];

    // slave / arbiter model configuration and state
    logic [31:0] cfg_base;
    int          cfg_n = 0, cfg_err = -1, cfg_drop = -1;
    bit          cfg_wait = 0;
    int          acc_cnt = 0, err_phase = 0, hold = 0;
    bit          dropped = 0, drop_now, busreq_seen = 0, gap_seen, last_acc;
    bit          dp_valid, prev_ready;
    logic [31:0] dp_addr, prev_addr;
    logic [1:0]  prev_trans;
    logic [1:0]  beat_trans [0:15];
    bit          exp_nonseq;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_valid = 0; prev_ready = 0; prev_trans = 2'b00; prev_addr = '0; dp_addr = '0;
            hold = 0; gap_seen = 1; last_acc = 0;
            bus.HGRANT = 1'b1; bus.HREADY = 1'b1; bus.HRESP = 2'b00; bus.HRDATA = '0;
        end else begin
            if (prev_ready) begin
                dp_valid = (prev_trans != 2'b00);
                dp_addr  = prev_addr;
            end
            if (last_acc) begin
                check("busreq_drop", bus.HBUSREQ, 1'b0);
                last_acc = 0;
            end
            if (bus.HBUSREQ) busreq_seen = 1;
            drop_now = 0;
            if (hold > 0) hold--;
            if (cfg_drop >= 0 && !dropped && bus.HTRANS != 2'b00 &&
                bus.HADDR == cfg_base + 32'(cfg_drop) * 4) begin
                hold = 5; dropped = 1; drop_now = 1;
            end
            bus.HGRANT = (hold == 0);
            bus.HRDATA = dp_valid ? mem_word(dp_addr) : $urandom;
            if (dp_valid && cfg_err >= 0 && err_phase < 2 &&
                dp_addr == cfg_base + 32'(cfg_err) * 4) begin
                bus.HRESP  = 2'b01;
                bus.HREADY = (err_phase == 1);
                err_phase++;
            end else begin
                bus.HRESP  = 2'b00;
                bus.HREADY = (cfg_wait && !drop_now) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (bus.HREADY && bus.HTRANS != 2'b00) begin
                exp_nonseq = (acc_cnt == 0) || gap_seen || (bus.HADDR[9:0] == 10'd0);
                check("haddr", bus.HADDR, cfg_base + 32'(acc_cnt) * 4);
                check("htrans", bus.HTRANS, exp_nonseq ? 2'b10 : 2'b11);
                if (acc_cnt < 16) beat_trans[acc_cnt] = bus.HTRANS;
                acc_cnt++;
                gap_seen = 0;
                if (acc_cnt == cfg_n) last_acc = 1;
            end else if (bus.HTRANS == 2'b00) begin
                gap_seen = 1;
            end
            prev_ready = bus.HREADY;
            prev_trans = bus.HTRANS;
            prev_addr  = bus.HADDR;
        end
    end

    logic [43:0] sb_e;
    always @(negedge HCLK) begin
        if (HRESETn && o_buf_we) begin
            last_we_cyc = cyc;
            check("sb_has_entry", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                check("buf_addr", o_buf_addr, sb_e[43:32]);
                check("buf_wdata", o_buf_wdata, sb_e[31:0]);
            end
        end
    end

    task automatic setup_job(input logic [31:0] base, input logic [24:0] size,
                             input int err_idx, input int drop_idx, input bit rnd,
                             output int n);
        int nw;
        n = (int'(size) + 3) >> 2;
        if (n > 4096) n = 4096;
        cfg_base = base & ~32'd3; cfg_n = n; cfg_err = err_idx; cfg_drop = drop_idx;
        cfg_wait = rnd; acc_cnt = 0; dropped = 0; err_phase = 0; busreq_seen = 0;
        for (int i = 0; i < 16; i++) beat_trans[i] = 2'b00;
        nw = (err_idx >= 0) ? err_idx : n;
        for (int k = 0; k < nw; k++)
            sb_q.push_back({k[11:0], mem_word(cfg_base + 32'(k) * 4)});
    endtask

    task automatic run_job(input string name, input logic [31:0] base, input logic [24:0] size,
                           input int err_idx, input int drop_idx, input bit rnd, input bit poke);
        int n;
        bit ok;
        setup_job(base, size, err_idx, drop_idx, rnd, n);
        @(negedge HCLK);
        i_base_addr = base; i_frame_size = size; i_start = 1'b1;
        @(negedge HCLK);
        i_start = 1'b0;
        check({name, "_busy"}, o_busy, n > 0);
        if (n == 0) check({name, "_done_next"}, o_done, 1'b1);
        if (poke) begin
            repeat (2) @(negedge HCLK);
            i_start = 1'b1;
            @(negedge HCLK);
            i_start = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < n * 8 + 200; i++) begin
            if (o_done) begin ok = 1; break; end
            @(negedge HCLK);
        end
        check({name, "_done"}, ok, 1'b1);
        check({name, "_err"}, o_err, err_idx >= 0);
        check({name, "_busy_end"}, o_busy, 1'b0);
        check({name, "_htrans_end"}, bus.HTRANS, 2'b00);
        check({name, "_sb_empty"}, sb_q.size(), 0);
        if (err_idx < 0) check({name, "_acc_cnt"}, acc_cnt, n);
        if (n > 0 && err_idx < 0 && ok) check({name, "_done_lat"}, cyc - last_we_cyc, 1);
        if (n == 0) check({name, "_no_busreq"}, busreq_seen, 1'b0);
    endtask

    int n_tmp;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; i_start = 1'b0; i_clear = 1'b0;
        i_base_addr = '0; i_frame_size = '0;
        repeat (3) @(negedge HCLK);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_we", o_buf_we, 1'b0);
        check("rst_busreq", bus.HBUSREQ, 1'b0);
        check("rst_htrans", bus.HTRANS, 2'b00);
        check("rst_haddr", bus.HADDR, 32'h0);
        check("hburst", bus.HBURST, 3'b001);
        check("hsize", bus.HSIZE, 3'b010);
        check("hwrite", bus.HWRITE, 1'b0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        run_job("t1", 32'h1000, 25'd16, -1, -1, 0, 0);
        check("t1_beat0", beat_trans[0], 2'b10);
        check("t1_beat1", beat_trans[1], 2'b11);
        check("t1_beat3", beat_trans[3], 2'b11);

        run_job("t2a", 32'h2003, 25'd13, -1, -1, 0, 0);
        run_job("t2b", 32'h2100, 25'd0, -1, -1, 0, 0);

        run_job("t3", 32'h13F8, 25'd16, -1, -1, 0, 0);
        check("t3_beat1", beat_trans[1], 2'b11);
        check("t3_beat2", beat_trans[2], 2'b10);
        check("t3_beat3", beat_trans[3], 2'b11);

        run_job("t4", 32'h4000, 25'd32, -1, 1, 1, 0);
        check("t4_beat1", beat_trans[1], 2'b11);
        check("t4_beat2", beat_trans[2], 2'b10);

        run_job("t5", 32'h5000, 25'd32, 2, -1, 0, 0);
        check("t5_done", o_done, 1'b1);
        @(negedge HCLK); i_clear = 1'b1;
        @(negedge HCLK); i_clear = 1'b0;
        check("clr_done", o_done, 1'b0);
        check("clr_err", o_err, 1'b0);

        run_job("t6", 32'h6000, 25'd32, -1, -1, 1, 1);
        repeat (3) @(negedge HCLK);
        check("t6_busy_after", o_busy, 1'b0);
        check("t6_done_hold", o_done, 1'b1);

        // start edge and clear in the same cycle: start wins
        setup_job(32'h7000, 25'd0, -1, -1, 0, n_tmp);
        @(negedge HCLK);
        i_frame_size = '0; i_clear = 1'b1; i_start = 1'b1;
        @(negedge HCLK);
        i_clear = 1'b0; i_start = 1'b0;
        check("start_clr_done", o_done, 1'b1);
        check("start_clr_err", o_err, 1'b0);

        // reset in the middle of a job
        setup_job(32'h3000, 25'd1024, -1, -1, 0, n_tmp);
        @(negedge HCLK);
        i_base_addr = 32'h3000; i_frame_size = 25'd1024; i_start = 1'b1;
        @(negedge HCLK);
        i_start = 1'b0;
        repeat (10) @(negedge HCLK);
        check("mid_busy_pre", o_busy, 1'b1);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_done", o_done, 1'b0);
        check("mid_rst_we", o_buf_we, 1'b0);
        check("mid_rst_busreq", bus.HBUSREQ, 1'b0);
        check("mid_rst_htrans", bus.HTRANS, 2'b00);
        check("mid_rst_haddr", bus.HADDR, 32'h0);
        sb_q.delete();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        run_job("t7", 32'h0, 25'h100_0000, -1, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
